serial_word_loader: RTL and testbench

Upstream stage for a bank of bit_regester cells. It accumulates a serial bit stream into a W-bit parallel word, holds the word stable, and issues a one-cycle load strobe that drives the l inputs of the downstream bit registers, with q driving their d inputs. A hold input lets the consumer stall the load. A ready output backpressures the serial source.

---
 rtl/serial_word_loader_pkg.sv | 16 +
 rtl/serial_word_loader_if.sv | 24 ++
 rtl/serial_word_loader_mod_counter.sv | 38 +++
 rtl/serial_word_loader.sv | 97 +++++++++
 tb/tb_serial_word_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial word loader:
// FSM encodings and counter sizing.
package serial_word_loader_pkg;

  localparam logic [1:0] S_SHIFT = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DEF_W  = 8;
  localparam int DEF_CW = cnt_w(DEF_W);

endpackage

// File: rtl/serial_word_loader_if.sv
// Serial-in / parallel-out handshake bundle
// between the bit source, loader and bit bank.
interface serial_word_loader_if #(
  parameter int W = 8
) ();

  logic         d;
  logic         v;
  logic         h;
  logic         rdy;
  logic [W-1:0] q;
  logic         l;

  modport master (
    output d, v, h,
    input  rdy, q, l
  );

  modport slave (
    input  d, v, h,
    output rdy, q, l
  );

endinterface

// File: rtl/serial_word_loader_mod_counter.sv
// Modulo-N counter with enable, sync clear and
// a terminal-count flag at N-1.
module mod_counter #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_loader.sv
// Accumulates a serial stream into a W-bit word
// and strobes it into a downstream register bank.
import serial_word_loader_pkg::*;

module serial_word_loader #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             c,
  input logic             r,
  serial_word_loader_if.slave s
);

  localparam int CW = cnt_w(W);

  logic [1:0]   state_q;
  logic [1:0]   state_d;
  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [W-1:0] shifted;
  logic         l_q;
  logic         l_d;
  logic         rdy;
  logic         acc;
  logic         cnt_en;
  logic         cnt_clr;
  logic         tc;

  assign rdy   = (state_q == S_SHIFT);
  assign acc   = s.v & rdy;
  assign s.rdy = rdy;
  assign s.q   = q_q;
  assign s.l   = l_q;

  generate
    if (W == 1) begin : g_one
      assign shifted = s.d;
    end else if (MSB_FIRST) begin : g_msb
      assign shifted = {q_q[W-2:0], s.d};
    end else begin : g_lsb
      assign shifted = {s.d, q_q[W-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_en  = 1'b0;
    unique case (1'b1)
      (state_q == S_SHIFT): begin
        if (acc) begin
          q_d    = shifted;
          cnt_en = 1'b1;
          if (tc) state_d = S_WAIT;
        end
      end
      (state_q == S_WAIT): begin
        if (!s.h) state_d = S_LOAD;
      end
      (state_q == S_LOAD): begin
        state_d = S_SHIFT;
      end
      default: begin
        state_d = S_SHIFT;
      end
    endcase
  end

  // Strobe is registered from the next state so l
  // coincides exactly with the LOAD cycle.
  assign l_d     = (state_d == S_LOAD);
  assign cnt_clr = (state_q != S_SHIFT);

  mod_counter #(
    .N  (W),
    .CW (CW)
  ) u_cnt (
    .clk   (c),
    .rst_n (r),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .tc    (tc)
  );

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      state_q <= S_SHIFT;
      q_q     <= '0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      l_q     <= l_d;
    end
  end

endmodule

// File: tb/tb_serial_word_loader.sv
// Self-checking bench: directed word table plus
// random traffic against a queue-based model.
module tb_serial_word_loader;

  logic c = 1'b0;
  logic r = 1'b0;
  logic d = 1'b0;
  logic v = 1'b0;
  logic h = 1'b0;

  int errors = 0;
  int checks = 0;
  int lcnt   = 0;

  always #5 c = ~c;

  serial_word_loader_if #(.W(8)) if_m ();
  serial_word_loader_if #(.W(8)) if_l ();
  serial_word_loader_if #(.W(1)) if_1 ();

  assign if_m.d = d;
  assign if_m.v = v;
  assign if_m.h = h;
  assign if_l.d = d;
  assign if_l.v = v;
  assign if_l.h = h;
  assign if_1.d = d;
  assign if_1.v = v;
  assign if_1.h = h;

  serial_word_loader #(.W(8), .MSB_FIRST(1'b1)) dut_m (
    .c (c), .r (r), .s (if_m)
  );
  serial_word_loader #(.W(8), .MSB_FIRST(1'b0)) dut_l (
    .c (c), .r (r), .s (if_l)
  );
  serial_word_loader #(.W(1), .MSB_FIRST(1'b1)) dut_1 (
    .c (c), .r (r), .s (if_1)
  );

  logic       rdy_o [3];
  logic       l_o   [3];
  logic [7:0] q_o   [3];

  assign rdy_o[0] = if_m.rdy;
  assign rdy_o[1] = if_l.rdy;
  assign rdy_o[2] = if_1.rdy;
  assign l_o[0]   = if_m.l;
  assign l_o[1]   = if_l.l;
  assign l_o[2]   = if_1.l;
  assign q_o[0]   = if_m.q;
  assign q_o[1]   = if_l.q;
  assign q_o[2]   = {7'b0, if_1.q};

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Reference: a word is a list of accepted bits;
  // once W are collected the word is pending until
  // a cycle with h=0, then shown for one load cycle.
  int         ww   [3] = '{8, 8, 1};
  bit         msb  [3] = '{1'b1, 1'b0, 1'b1};
  bit         pend [3] = '{0, 0, 0};
  bit         load [3] = '{0, 0, 0};
  logic [7:0] ew   [3] = '{8'h0, 8'h0, 8'h0};
  bit         bq   [3][$];

  initial begin
    forever begin
      @(posedge c or negedge r);
      for (int i = 0; i < 3; i++) begin
        if (!r) begin
          pend[i] = 0;
          load[i] = 0;
          bq[i].delete();
        end else begin
          bit nl;
          bit np;
          nl = pend[i] && !h;
          np = pend[i] && h;
          if (v && !pend[i] && !load[i]) begin
            bq[i].push_back(d);
            if (bq[i].size() == ww[i]) begin
              int n;
              logic [7:0] wv;
              n  = ww[i];
              wv = '0;
              for (int k = 0; k < n; k++) begin
                if (msb[i])
                  wv = wv + (8'(bq[i][k]) << (n - 1 - k));
                else
                  wv = wv + (8'(bq[i][k]) << k);
              end
              ew[i] = wv;
              bq[i].delete();
              np = 1;
            end
          end
          load[i] = nl;
          pend[i] = np;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge c);
      if (l_o[0] === 1'b1) lcnt++;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("mdl_rdy%0d", i),
            32'(rdy_o[i]), 32'(!pend[i] && !load[i]));
        chk($sformatf("mdl_l%0d", i),
            32'(l_o[i]), 32'(load[i]));
        if (load[i])
          chk($sformatf("mdl_q%0d", i),
              32'(q_o[i]), 32'(ew[i]));
      end
    end
  end

  // Called right after a rising edge; returns right
  // after the edge that accepted the bit.
  task automatic send_bit(input bit b, input int gap);
    bit ok;
    v = 1'b0;
    repeat (gap) begin
      @(posedge c);
      #1;
    end
    v = 1'b1;
    d = b;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge c);
      ok = rdy_o[0];
      @(posedge c);
      #1;
    end
    v = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got rdy 0 want 1");
    end
  endtask

  typedef struct {
    logic [7:0] word;
    int         hold;
    bit         junk;
    bit         rst_first;
    bit         gap;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t tv [8];

  initial begin
    tv[0] = '{8'hB2, 0, 1'b0, 1'b0, 1'b0, 8'hB2, 8'h4D};
    tv[1] = '{8'hB2, 5, 1'b0, 1'b0, 1'b0, 8'hB2, 8'h4D};
    tv[2] = '{8'h0F, 3, 1'b1, 1'b0, 1'b0, 8'h0F, 8'hF0};
    tv[3] = '{8'hA5, 0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5};
    for (int i = 4; i < 8; i++)
      tv[i] = '{8'h3C, 0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h3C};

    repeat (2) @(posedge c);
    #1 r = 1'b1;
    chk("rst_q_m", 32'(q_o[0]), 32'h0);
    chk("rst_q_l", 32'(q_o[1]), 32'h0);
    chk("rst_l", 32'(l_o[0]), 32'h0);
    chk("rst_rdy", 32'(rdy_o[0]), 32'h1);

    for (int n = 0; n < 8; n++) begin
      int nw;
      if (tv[n].rst_first) begin
        for (int k = 0; k < 3; k++) send_bit(1'b1, 0);
        #2 r = 1'b0;
        #1;
        chk("arst_q_m", 32'(q_o[0]), 32'h0);
        chk("arst_q_l", 32'(q_o[1]), 32'h0);
        chk("arst_l", 32'(l_o[0]), 32'h0);
        chk("arst_rdy", 32'(rdy_o[0]), 32'h1);
        #3 r = 1'b1;
        @(posedge c);
        #1;
      end
      h = (tv[n].hold > 0);
      for (int b = 7; b >= 0; b--) begin
        int g;
        g = 0;
        if (tv[n].gap && ($urandom % 2 == 1))
          g = $urandom_range(1, 4);
        send_bit(tv[n].word[b], g);
      end
      v  = tv[n].junk;
      d  = 1'b1;
      nw = (tv[n].hold > 0) ? tv[n].hold : 1;
      for (int k = 0; k < nw; k++) begin
        @(negedge c);
        chk("wait_rdy", 32'(rdy_o[0]), 32'h0);
        chk("wait_l", 32'(l_o[0]), 32'h0);
        chk("wait_q_m", 32'(q_o[0]), 32'(tv[n].exp_m));
        chk("wait_q_l", 32'(q_o[1]), 32'(tv[n].exp_l));
        if (k == nw - 1) begin
          h = 1'b0;
          v = 1'b0;
        end
      end
      @(negedge c);
      chk("load_l", 32'(l_o[0]), 32'h1);
      chk("load_rdy", 32'(rdy_o[0]), 32'h0);
      chk("load_q_m", 32'(q_o[0]), 32'(tv[n].exp_m));
      chk("load_q_l", 32'(q_o[1]), 32'(tv[n].exp_l));
      @(negedge c);
      chk("post_l", 32'(l_o[0]), 32'h0);
      chk("post_rdy", 32'(rdy_o[0]), 32'h1);
      @(posedge c);
      #1;
    end
    chk("pulse_count", 32'(lcnt), 32'd8);

    repeat (400) begin
      v = ($urandom % 4 != 0);
      d = 1'($urandom);
      h = ($urandom % 3 == 0);
      @(posedge c);
      #1;
    end
    v = 1'b0;
    h = 1'b0;
    repeat (12) @(posedge c);
    #1;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
